// File: rtl/int2fp_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : int2fp_seq_if
// Description : Operand/result handshake bundle for the int2fp_seq converter.
// Revision    : 1.0  initial release
// ============================================================================
interface int2fp_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_inexact;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_inexact
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_inexact
    );
endinterface
`default_nettype wire

// File: rtl/int2fp_seq.sv
`default_nettype none
// ============================================================================
// Module      : int2fp_seq
// Description : Sequential signed int32 to IEEE-754 single converter (RNE).
// Revision    : 1.0  initial release
// ============================================================================
module int2fp_seq (
    input  wire logic   clk,
    input  wire logic   rst_n,
    int2fp_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] c_EXP_INIT = 8'd158;

    state_t      r_state;
    state_t      w_next;
    logic        r_sign;
    logic [31:0] r_mag;
    logic [7:0]  r_exp;
    logic [31:0] r_out_data;
    logic        r_out_inexact;

    logic        w_accept;
    logic        w_in_zero;
    logic [31:0] w_abs;
    logic        w_guard;
    logic        w_sticky;
    logic        w_round_up;
    logic [23:0] w_frac_inc;
    logic        w_carry;
    logic [22:0] w_frac_rnd;
    logic [7:0]  w_exp_rnd;

    assign w_accept  = (r_state == S_IDLE) && bus.in_valid;
    assign w_in_zero = (bus.in_data == 32'd0);
    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    assign w_abs     = bus.in_data[31] ? (~bus.in_data + 32'd1) : bus.in_data;

    assign w_guard    = r_mag[7];
    assign w_sticky   = |r_mag[6:0];
    assign w_round_up = w_guard & (w_sticky | r_mag[8]);
    assign w_frac_inc = {1'b0, r_mag[30:8]} + {23'd0, w_round_up};
    assign w_carry    = w_frac_inc[23];
    assign w_frac_rnd = w_frac_inc[22:0];
    assign w_exp_rnd  = r_exp + {7'd0, w_carry};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_next = w_in_zero ? S_DONE : S_NORM;
            S_NORM:  if (r_mag[31]) w_next = S_ROUND;
            S_ROUND: w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign        <= 1'b0;
            r_mag         <= 32'd0;
            r_exp         <= 8'd0;
            r_out_data    <= 32'd0;
            r_out_inexact <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sign <= bus.in_data[31];
                r_mag  <= w_abs;
                r_exp  <= c_EXP_INIT;
                if (w_in_zero) begin
                    r_out_data    <= 32'd0;
                    r_out_inexact <= 1'b0;
                end
            end
            if ((r_state == S_NORM) && !r_mag[31]) begin
                r_mag <= {r_mag[30:0], 1'b0};
                r_exp <= r_exp - 8'd1;
            end
            // A fraction carry leaves w_frac_rnd at zero and bumps the exponent
            if (r_state == S_ROUND) begin
                r_out_data    <= {r_sign, w_exp_rnd, w_frac_rnd};
                r_out_inexact <= w_guard | w_sticky;
            end
        end
    end

    assign bus.in_ready    = (r_state == S_IDLE);
    assign bus.out_valid   = (r_state == S_DONE);
    assign bus.out_data    = r_out_data;
    assign bus.out_inexact = r_out_inexact;

endmodule
`default_nettype wire

// File: tb/tb_int2fp_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_int2fp_seq
// Description : Directed and reference-checked bench for int2fp_seq.
// Revision    : 1.0  initial release
// ============================================================================
module tb_int2fp_seq;

    logic clk;
    logic rst_n;
    int   checks;
    int   passes;
    int   fails;

    int2fp_seq_if bus_if ();

    int2fp_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Independent reference: locate MSB, shift to 24 bits, round by remainder
    function automatic void ref_fp(input logic [31:0] x, output logic [31:0] f,
                                   output logic inex, output int lat);
        logic [31:0] mag;
        logic [63:0] mant;
        logic [63:0] rem;
        logic [63:0] half;
        int          p;
        int          sh;
        logic [7:0]  e;
        mag = x[31] ? (32'd0 - x) : x;
        if (mag == 32'd0) begin
            f = 32'd0; inex = 1'b0; lat = 1;
            return;
        end
        p = 31;
        while (!mag[p]) p--;
        lat = (31 - p) + 3;
        if (p <= 23) begin
            mant = {32'd0, mag} << (23 - p);
            inex = 1'b0;
        end else begin
            sh   = p - 23;
            mant = {32'd0, mag} >> sh;
            rem  = {32'd0, mag} & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            inex = (rem != 64'd0);
            if ((rem > half) || ((rem == half) && mant[0])) mant = mant + 64'd1;
            if (mant[24]) begin
                mant = mant >> 1;
                p++;
            end
        end
        e = 8'(127 + p);
        f = {x[31], e, mant[22:0]};
    endfunction

    task automatic convert(input string tag, input logic [31:0] din, input logic [31:0] exp_data,
                           input logic exp_inex, input int exp_lat, input int stall);
        int          cyc;
        logic [31:0] held;
        @(negedge clk);
        check({tag, ".in_ready"}, {31'd0, bus_if.in_ready}, 32'd1);
        bus_if.in_valid  = 1'b1;
        bus_if.in_data   = din;
        bus_if.out_ready = (stall == 0);
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = $urandom;
        cyc = 1;
        while (!bus_if.out_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, ".out_valid"}, {31'd0, bus_if.out_valid}, 32'd1);
        check({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, ".data"}, bus_if.out_data, exp_data);
        check({tag, ".inexact"}, {31'd0, bus_if.out_inexact}, {31'd0, exp_inex});
        held = bus_if.out_data;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check({tag, ".stall_data"}, bus_if.out_data, held);
            check({tag, ".stall_rdy"}, {30'd0, bus_if.in_ready, bus_if.out_valid}, 32'd1);
        end
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".back_idle"}, {30'd0, bus_if.in_ready, bus_if.out_valid}, 32'd2);
    endtask

    initial begin
        logic [31:0] rf;
        logic        ri;
        int          rl;
        logic [31:0] x;
        logic        stale;
        checks = 0; passes = 0; fails = 0;
        rst_n = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = 32'd0;
        bus_if.out_ready = 1'b1;
        #12;
        check("rst.outs", {bus_if.in_ready, bus_if.out_valid, bus_if.out_inexact, 29'd0}, 32'h8000_0000);
        check("rst.data", bus_if.out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        convert("one",      32'h0000_0001, 32'h3F80_0000, 1'b0, 34, 0);
        convert("minus1",   32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 34, 0);
        convert("intmin",   32'h8000_0000, 32'hCF00_0000, 1'b0, 3,  0);
        convert("zero",     32'h0000_0000, 32'h0000_0000, 1'b0, 1,  0);
        convert("tie_down", 32'h0100_0001, 32'h4B80_0000, 1'b1, 10, 0);
        convert("tie_up",   32'h0100_0003, 32'h4B80_0002, 1'b1, 10, 0);
        convert("carry",    32'h7FFF_FFFF, 32'h4F00_0000, 1'b1, 4,  0);
        convert("exact24",  32'h00FF_FFFF, 32'h4B7F_FFFF, 1'b0, 11, 0);
        convert("neg256",   32'hFFFF_FF00, 32'hC380_0000, 1'b0, 26, 0);
        convert("bp_three", 32'h0000_0003, 32'h4040_0000, 1'b0, 33, 10);

        // Reset in the middle of normalising 5
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 32'd5;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.outs", {bus_if.in_ready, bus_if.out_valid, bus_if.out_inexact, 29'd0}, 32'h8000_0000);
        check("midrst.data", bus_if.out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus_if.out_valid) stale = 1'b1;
        end
        check("midrst.no_stale", {31'd0, stale}, 32'd0);
        convert("five", 32'd5, 32'h40A0_0000, 1'b0, 32, 0);

        for (int k = 0; k < 16; k++) begin
            x = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) x = 32'd0 - x;
            ref_fp(x, rf, ri, rl);
            convert("rand", x, rf, ri, rl, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
